komandara_axi4lite2bus: RTL and testbench
=========================================

Name: komandara_axi4lite2bus

Overview:
AXI4-Lite slave to simple-bus bridge; the counterpart of the K10 simple-bus-to-AXI4-Lite master bridge.
- Accepts AXI4-Lite reads and writes from an interconnect.
- Replays each one as a single req/gnt + rvalid/rdata transaction towards a simple-bus responder (SRAM, peripheral register block).
- Returns the result as an AXI4-Lite B or R response.
- One transaction is outstanding on the simple bus at a time.

Parameters:
- ADDR_WIDTH, 32, address width on both sides.
- DATA_WIDTH, 32, data width on both sides (multiple of 8).
- TIMEOUT_CYCLES, 256, response timeout in cycles; used only with KOMANDARA_AXI2BUS_TIMEOUT_EN.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- s_axi_awaddr  in  ADDR_WIDTH  write address
- s_axi_awprot  in  3  write protection (accepted, ignored)
- s_axi_awvalid  in  1  / s_axi_awready  out  1
- s_axi_wdata  in  DATA_WIDTH / s_axi_wstrb  in  DATA_WIDTH/8
- s_axi_wvalid  in  1  / s_axi_wready  out  1
- s_axi_bresp  out  2  / s_axi_bvalid  out  1  / s_axi_bready  in  1
- s_axi_araddr  in  ADDR_WIDTH / s_axi_arprot  in  3 (ignored)
- s_axi_arvalid  in  1  / s_axi_arready  out  1
- s_axi_rdata  out  DATA_WIDTH / s_axi_rresp  out  2
- s_axi_rvalid  out  1  / s_axi_rready  in  1
- o_req  out  1  simple-bus request
- o_we  out  1  1 = write
- o_addr  out  ADDR_WIDTH / o_wdata  out  DATA_WIDTH / o_wstrb  out  DATA_WIDTH/8
- i_gnt  in  1  request accepted
- i_rvalid  in  1  response valid (reads and writes)
- i_rdata  in  DATA_WIDTH / i_err  in  1  error qualifier with i_rvalid

Behaviour:
Reset:
- Async reset clears everything: o_req, s_axi_bvalid, s_axi_rvalid = 0; bresp, rresp, rdata, o_addr, o_wdata, o_wstrb, o_we = 0.
- AW, W and AR holding buffers empty; FSM returns to ST_IDLE.
- Reset mid-transaction drops it silently; no response is issued.

Address and data capture:
- Three independent one-entry holding registers: AW, W, AR.
- awready = !aw_full, wready = !w_full, arready = !ar_full. These are 1 out of reset.
- A buffer fills on valid && ready and empties when its transaction is launched (ST_IDLE to ST_REQ).
- AW and W may arrive in any order or in the same cycle. A write is pending only when both AW and W are full.

FSM states:
- ST_IDLE
  - No pending transaction: stay.
  - Only a write pending: launch write.
  - Only a read pending: launch read.
  - Both pending: round-robin on r_last_wr (reset 0, so the write wins the first tie), then r_last_wr toggles.
  - Launch drives o_addr, o_we, o_wdata, o_wstrb from the buffer, then goes to ST_REQ.
- ST_REQ
  - o_req = 1; address and data held stable.
  - On i_gnt: go to ST_WAIT_RSP.
- ST_WAIT_RSP
  - o_req = 0.
  - i_rvalid is sampled only in this state. The responder must not assert rvalid in the gnt cycle; rvalid in ST_REQ is ignored.
  - On i_rvalid, register the response:
    - Read: rdata = i_rdata, rresp = i_err ? 2'b10 (SLVERR) : 2'b00, rvalid = 1, go to ST_RRESP.
    - Write: bresp with the same encoding, bvalid = 1, go to ST_BRESP.
- ST_RRESP / ST_BRESP
  - Hold valid and payload until rready / bready, then clear valid and go to ST_IDLE.

Latency:
- AR accepted at cycle 0.
- o_req at cycle 1; gnt at cycle 1; rvalid at cycle 2.
- s_axi_rvalid at cycle 3. Zero-wait best case is a 3-cycle AR-to-R latency.

Concurrency:
- New AW, W and AR beats are accepted into empty buffers during any state, so up to one read and one write are queued behind the active transaction.
- No other response code is generated; EXOKAY is never returned.

Optional Feature:
Macro: KOMANDARA_AXI2BUS_TIMEOUT_EN
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on launch and increments each cycle in ST_REQ or ST_WAIT_RSP.
  - When it reaches TIMEOUT_CYCLES: o_req drops and the FSM issues SLVERR (rdata = 0 for reads) via ST_RRESP / ST_BRESP.
  - A late i_gnt or i_rvalid arriving outside ST_REQ / ST_WAIT_RSP is ignored.
- Undefined: no counter; the bridge waits indefinitely; TIMEOUT_CYCLES is unused.

Test Plan:
- Read at 0x1000: responder gnt same cycle, rvalid next cycle with rdata 0xDEADBEEF, err = 0 -> R beat rdata 0xDEADBEEF, rresp 00, 3 cycles after AR handshake.
- Write with W (0xA5A5A5A5, wstrb 4'b0011) two cycles before AW (0x20) -> exactly one o_req with o_we = 1, o_addr 0x20, o_wdata 0xA5A5A5A5, o_wstrb 0011 after AW; bresp 00.
- AR and complete AW+W presented in the same cycle after reset -> write issued first, read second; a repeated tie afterwards serves the read first.
- Responder returns i_err = 1 on a read and on a write -> rresp = 10 and bresp = 10, rdata = i_rdata.
- rready held low 5 cycles with a second AR queued -> rvalid and rdata stable for 5 cycles, no second o_req until the R handshake, arready = 0 while AR is full.
- Timeout enabled, TIMEOUT_CYCLES = 8, responder never asserts gnt -> o_req drops after 8 cycles, rresp = 10, rdata = 0; a later stray rvalid is ignored.
- Additional check: async reset asserted while in ST_WAIT_RSP -> all valids 0 immediately, no response after reset release.

Source files
------------

// File: rtl/komandara_axi4lite2bus.sv
// komandara_axi4lite2bus: AXI4-Lite slave to simple-bus bridge, one bus transaction in flight.
// Optional response timeout when KOMANDARA_AXI2BUS_TIMEOUT_EN is defined.
module komandara_axi4lite2bus #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]              s_axi_awprot,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]              s_axi_arprot,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic                    o_req,
    output logic                    o_we,
    output logic [ADDR_WIDTH-1:0]   o_addr,
    output logic [DATA_WIDTH-1:0]   o_wdata,
    output logic [DATA_WIDTH/8-1:0] o_wstrb,
    input  logic                    i_gnt,
    input  logic                    i_rvalid,
    input  logic [DATA_WIDTH-1:0]   i_rdata,
    input  logic                    i_err
);
    localparam int SW = DATA_WIDTH / 8;

    typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_WAIT_RSP, ST_RRESP, ST_BRESP} state_t;

    state_t                state, state_nxt, done_st;
    logic                  aw_full, w_full, ar_full, last_wr;
    logic [ADDR_WIDTH-1:0] aw_addr, ar_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [SW-1:0]         w_strb;
    logic                  wr_pend, rd_pend, pick_wr, launch, rsp, timeout, tmo_fire;
    logic                  unused_prot;

    assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

`ifdef KOMANDARA_AXI2BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) cnt <= '0;
        else if (launch) cnt <= '0;
        else if (state == ST_REQ || state == ST_WAIT_RSP) cnt <= cnt + 1'b1;
    // fires on the cycle whose increment makes the counter reach TIMEOUT_CYCLES
    assign timeout = (state == ST_REQ || state == ST_WAIT_RSP) && cnt == CW'(TIMEOUT_CYCLES - 1);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        wr_pend  = aw_full && w_full;
        rd_pend  = ar_full;
        pick_wr  = wr_pend && !(rd_pend && last_wr);
        launch   = state == ST_IDLE && (wr_pend || rd_pend);
        rsp      = state == ST_WAIT_RSP && i_rvalid;
        tmo_fire = timeout && !(state == ST_REQ && i_gnt) && !rsp;
        done_st  = o_we ? ST_BRESP : ST_RRESP;
    end

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) state <= ST_IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     state_nxt = launch ? ST_REQ : ST_IDLE;
            ST_REQ:      state_nxt = i_gnt ? ST_WAIT_RSP : (timeout ? done_st : ST_REQ);
            ST_WAIT_RSP: state_nxt = (i_rvalid || timeout) ? done_st : ST_WAIT_RSP;
            ST_RRESP:    state_nxt = s_axi_rready ? ST_IDLE : ST_RRESP;
            ST_BRESP:    state_nxt = s_axi_bready ? ST_IDLE : ST_BRESP;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_req         = state == ST_REQ;
        s_axi_rvalid  = state == ST_RRESP;
        s_axi_bvalid  = state == ST_BRESP;
        s_axi_awready = !aw_full;
        s_axi_wready  = !w_full;
        s_axi_arready = !ar_full;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            aw_full     <= 1'b0;
            w_full      <= 1'b0;
            ar_full     <= 1'b0;
            last_wr     <= 1'b0;
            aw_addr     <= '0;
            ar_addr     <= '0;
            w_data      <= '0;
            w_strb      <= '0;
            o_we        <= 1'b0;
            o_addr      <= '0;
            o_wdata     <= '0;
            o_wstrb     <= '0;
            s_axi_bresp <= 2'b00;
            s_axi_rresp <= 2'b00;
            s_axi_rdata <= '0;
        end else begin
            if (s_axi_awvalid && !aw_full) begin
                aw_full <= 1'b1;
                aw_addr <= s_axi_awaddr;
            end
            if (s_axi_wvalid && !w_full) begin
                w_full <= 1'b1;
                w_data <= s_axi_wdata;
                w_strb <= s_axi_wstrb;
            end
            if (s_axi_arvalid && !ar_full) begin
                ar_full <= 1'b1;
                ar_addr <= s_axi_araddr;
            end
            // launch only empties full buffers, which cannot be refilled in the same cycle
            if (launch) begin
                last_wr <= (wr_pend && rd_pend) ? !last_wr : last_wr;
                o_we    <= pick_wr;
                o_addr  <= pick_wr ? aw_addr : ar_addr;
                o_wdata <= pick_wr ? w_data : '0;
                o_wstrb <= pick_wr ? w_strb : '0;
                if (pick_wr) begin
                    aw_full <= 1'b0;
                    w_full  <= 1'b0;
                end else begin
                    ar_full <= 1'b0;
                end
            end
            if (rsp || tmo_fire) begin
                if (o_we) begin
                    s_axi_bresp <= rsp ? {i_err, 1'b0} : 2'b10;
                end else begin
                    s_axi_rdata <= rsp ? i_rdata : '0;
                    s_axi_rresp <= rsp ? {i_err, 1'b0} : 2'b10;
                end
            end
        end
    end
endmodule

// File: tb/tb_komandara_axi4lite2bus.sv
// tb_komandara_axi4lite2bus: directed tests against a queue-based transaction model of the bridge.
module tb_komandara_axi4lite2bus;
    logic        clk = 0, rst_n = 0;
    logic [31:0] s_axi_awaddr = 0, s_axi_wdata = 0, s_axi_araddr = 0, s_axi_rdata;
    logic [3:0]  s_axi_wstrb = 0, o_wstrb;
    logic [2:0]  s_axi_awprot = 0, s_axi_arprot = 0;
    logic        s_axi_awvalid = 0, s_axi_wvalid = 0, s_axi_arvalid = 0;
    logic        s_axi_awready, s_axi_wready, s_axi_arready;
    logic [1:0]  s_axi_bresp, s_axi_rresp;
    logic        s_axi_bvalid, s_axi_rvalid;
    logic        s_axi_bready = 1, s_axi_rready = 1;
    logic        o_req, o_we;
    logic [31:0] o_addr, o_wdata;
    logic        i_gnt, i_rvalid, i_err;
    logic [31:0] i_rdata;

    komandara_axi4lite2bus #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr),
        .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready), .o_req(o_req), .o_we(o_we), .o_addr(o_addr),
        .o_wdata(o_wdata), .o_wstrb(o_wstrb), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bus_t;

    bus_t        exp_bus[$];
    logic [33:0] exp_r[$];
    logic [1:0]  exp_b[$];
    int          n_vec = 0, n_err = 0, cyc = 0, ar_edge = 0, ties = 0;
    bit          gnt_en = 1, rsp_en = 1, stray = 0, gnt_prev = 0, rsp_err = 0;
    logic [31:0] rsp_data = 0;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s (edge %0d)", name, cyc);
    endtask

    task automatic push_bus(input logic [31:0] a, input logic we, input logic [31:0] d, input logic [3:0] s);
        bus_t e;
        e.addr = a;
        e.we = we;
        e.wdata = d;
        e.wstrb = s;
        exp_bus.push_back(e);
    endtask

    // responder: grant in the request cycle, answer in the following cycle
    initial begin
        i_gnt = 0; i_rvalid = 0; i_rdata = 0; i_err = 0;
        forever begin
            @(negedge clk);
            i_rvalid = (gnt_prev && rsp_en) || stray;
            stray    = 0;
            i_rdata  = rsp_data;
            i_err    = rsp_err;
            gnt_prev = o_req && gnt_en;
            i_gnt    = gnt_prev;
        end
    end

    // compare process: every handshake about to be sampled must match the model queues
    initial forever begin
        bus_t        e;
        logic [33:0] r;
        @(negedge clk);
        #1;
        if (rst_n) begin
            if (o_req && i_gnt) begin
                if (exp_bus.size() == 0) fail("unexpected_bus_req");
                else begin
                    e = exp_bus.pop_front();
                    chk("bus_addr", o_addr, e.addr);
                    chk("bus_we", o_we, e.we);
                    if (e.we) begin
                        chk("bus_wdata", o_wdata, e.wdata);
                        chk("bus_wstrb", o_wstrb, e.wstrb);
                    end
                end
            end
            if (s_axi_rvalid && s_axi_rready) begin
                if (exp_r.size() == 0) fail("unexpected_r_beat");
                else begin
                    r = exp_r.pop_front();
                    chk("rdata", s_axi_rdata, r[31:0]);
                    chk("rresp", s_axi_rresp, r[33:32]);
                end
            end
            if (s_axi_bvalid && s_axi_bready) begin
                if (exp_b.size() == 0) fail("unexpected_b_beat");
                else chk("bresp", s_axi_bresp, exp_b.pop_front());
            end
        end
    end

    task automatic send(input bit a, input bit w, input bit r);
        bit ha, hw, hr;
        s_axi_awvalid = a;
        s_axi_wvalid  = w;
        s_axi_arvalid = r;
        for (int i = 0; i < 50 && (s_axi_awvalid || s_axi_wvalid || s_axi_arvalid); i++) begin
            ha = s_axi_awvalid && s_axi_awready;
            hw = s_axi_wvalid && s_axi_wready;
            hr = s_axi_arvalid && s_axi_arready;
            if (hr) ar_edge = cyc + 1;
            @(negedge clk);
            if (ha) s_axi_awvalid = 0;
            if (hw) s_axi_wvalid = 0;
            if (hr) s_axi_arvalid = 0;
        end
        if (s_axi_awvalid || s_axi_wvalid || s_axi_arvalid) begin
            fail("send_handshake_timeout");
            s_axi_awvalid = 0;
            s_axi_wvalid  = 0;
            s_axi_arvalid = 0;
        end
    endtask

    task automatic wait_rv();
        for (int i = 0; i < 60 && !s_axi_rvalid; i++) @(negedge clk);
        if (!s_axi_rvalid) fail("rvalid_timeout");
    endtask

    task automatic wait_done();
        bit done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = exp_bus.size() == 0 && exp_r.size() == 0 && exp_b.size() == 0 &&
                   !o_req && !s_axi_rvalid && !s_axi_bvalid;
        end
        if (!done) fail("drain_timeout");
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_o_req", o_req, 0);
        chk("rst_rvalid", s_axi_rvalid, 0);
        chk("rst_bvalid", s_axi_bvalid, 0);
        chk("rst_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
        chk("rst_o_addr", o_addr, 0);
        chk("rst_o_we", o_we, 0);
        chk("rst_rdata", s_axi_rdata, 0);
        rst_n = 1;
        @(negedge clk);

        // plain read, zero-wait responder
        s_axi_araddr = 32'h1000;
        rsp_data = 32'hDEADBEEF;
        push_bus(32'h1000, 0, 0, 0);
        exp_r.push_back({2'b00, 32'hDEADBEEF});
        send(0, 0, 1);
        wait_rv();
        chk("r_latency_edges", cyc - ar_edge, 3);
        chk("first_rdata_literal", s_axi_rdata, 32'hDEADBEEF);
        chk("first_rresp_literal", s_axi_rresp, 2'b00);
        wait_done();

        // W two cycles ahead of AW
        s_axi_wdata = 32'hA5A5A5A5;
        s_axi_wstrb = 4'b0011;
        s_axi_awaddr = 32'h20;
        push_bus(32'h20, 1, 32'hA5A5A5A5, 4'b0011);
        exp_b.push_back(2'b00);
        send(0, 1, 0);
        chk("w_only_no_req_0", o_req, 0);
        @(negedge clk);
        chk("w_only_no_req_1", o_req, 0);
        chk("w_only_awready", s_axi_awready, 1);
        send(1, 0, 0);
        wait_done();

        // two ties after reset: model alternates starting with the write
        reset_dut();
        for (int k = 0; k < 2; k++) begin
            s_axi_awaddr = 32'h40 + 4 * k;
            s_axi_wdata  = 32'h11112222 + k;
            s_axi_wstrb  = 4'hF;
            s_axi_araddr = 32'h80 + 4 * k;
            rsp_data     = 32'h33334444 + k;
            if (ties % 2 == 0) begin
                push_bus(s_axi_awaddr, 1, s_axi_wdata, 4'hF);
                push_bus(s_axi_araddr, 0, 0, 0);
            end else begin
                push_bus(s_axi_araddr, 0, 0, 0);
                push_bus(s_axi_awaddr, 1, s_axi_wdata, 4'hF);
            end
            ties++;
            exp_b.push_back(2'b00);
            exp_r.push_back({2'b00, rsp_data});
            send(1, 1, 1);
            wait_done();
        end

        // responder error on read and write
        rsp_err = 1;
        rsp_data = 32'h0BADF00D;
        s_axi_araddr = 32'h100;
        push_bus(32'h100, 0, 0, 0);
        exp_r.push_back({2'b10, 32'h0BADF00D});
        send(0, 0, 1);
        wait_done();
        s_axi_awaddr = 32'h104;
        s_axi_wdata = 32'h5555AAAA;
        s_axi_wstrb = 4'b1000;
        push_bus(32'h104, 1, 32'h5555AAAA, 4'b1000);
        exp_b.push_back(2'b10);
        send(1, 1, 0);
        wait_done();
        rsp_err = 0;

        // R backpressure with a second AR queued
        s_axi_rready = 0;
        rsp_data = 32'h12345678;
        s_axi_araddr = 32'h200;
        push_bus(32'h200, 0, 0, 0);
        exp_r.push_back({2'b00, 32'h12345678});
        send(0, 0, 1);
        wait_rv();
        s_axi_araddr = 32'h204;
        push_bus(32'h204, 0, 0, 0);
        exp_r.push_back({2'b00, 32'h9ABCDEF0});
        send(0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            chk("hold_rvalid", s_axi_rvalid, 1);
            chk("hold_rdata", s_axi_rdata, 32'h12345678);
            chk("hold_no_req", o_req, 0);
            chk("hold_arready", s_axi_arready, 0);
            @(negedge clk);
        end
        rsp_data = 32'h9ABCDEF0;
        s_axi_rready = 1;
        wait_done();

`ifdef KOMANDARA_AXI2BUS_TIMEOUT_EN
        // responder never grants
        gnt_en = 0;
        s_axi_araddr = 32'h300;
        exp_r.push_back({2'b10, 32'h0});
        send(0, 0, 1);
        n = 0;
        for (int i = 0; i < 40 && !s_axi_rvalid; i++) begin
            if (o_req) n++;
            @(negedge clk);
        end
        chk("timeout_req_cycles", n, 8);
        chk("timeout_o_addr", o_addr, 32'h300);
        wait_done();
        gnt_en = 1;
        #2 stray = 1;
        repeat (4) @(negedge clk);
        chk("stray_no_rvalid", s_axi_rvalid, 0);
        chk("stray_no_req", o_req, 0);
`endif

        // async reset while waiting for the response
        rsp_en = 0;
        s_axi_araddr = 32'h400;
        push_bus(32'h400, 0, 0, 0);
        exp_r.push_back({2'b00, 32'h0});
        send(0, 0, 1);
        n = 0;
        while (exp_bus.size() != 0 && n < 20) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (exp_bus.size() != 0) fail("reset_test_no_grant");
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("async_rst_o_req", o_req, 0);
        chk("async_rst_rvalid", s_axi_rvalid, 0);
        chk("async_rst_bvalid", s_axi_bvalid, 0);
        chk("async_rst_arready", s_axi_arready, 1);
        exp_r.delete();
        @(negedge clk);
        rsp_en = 1;
        rst_n = 1;
        repeat (10) @(negedge clk);
        chk("post_rst_no_rvalid", s_axi_rvalid, 0);
        chk("post_rst_no_req", o_req, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
